// File: rtl/pixel_src_sched.sv
// Frame-synchronous pixel source scheduler. It issues paced reads to either the
// color-bar generator or the SRAM controller and buffers the returned pixels for VGA pulls.
module pixel_src_sched #(
  parameter int          DEPTH        = 8,
  parameter int          MAX_OUTST    = 4,
  parameter int          ADDR_W       = 19,
  parameter int          FRAME_PIXELS = 480000,
  parameter logic [15:0] BLANK        = 16'h0000
) (
  input  logic              CLK_40M,
  input  logic              SYS_RST,
  input  logic [1:0]        REG_SELECT,
  input  logic              VGA_FRAME_START,
  input  logic              VGA_REQ,
  output logic              PIX_DVLD,
  output logic [15:0]       PIX_DATA,
  output logic              CLRB_REQ,
  input  logic              CLRB_DVLD,
  input  logic [15:0]       CLRB_DATA,
  output logic              SRAM_RD_REQ,
  output logic [ADDR_W-1:0] SRAM_RD_ADDR,
  input  logic              SRAM_CTRL_DVLD,
  input  logic [15:0]       SRAM_CTRL_DATA,
  output logic              UNDERFLOW
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ISS_W = $clog2(FRAME_PIXELS + 1);

  localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MAXO_C  = CNT_W'(MAX_OUTST);
  localparam logic [ISS_W-1:0] FRAME_C = ISS_W'(FRAME_PIXELS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREFETCH,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t             state_q, state_d;
  logic               sel_clrb_q, sel_clrb_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ISS_W-1:0]   issued_q, issued_d;
  logic [CNT_W-1:0]   outst_q, outst_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               pix_dvld_q, pix_dvld_d;
  logic [15:0]        pix_data_q, pix_data_d;
  logic               underflow_q, underflow_d;

  logic [15:0]        mem [DEPTH];

  logic               active;
  logic               req;
  logic               ret_dvld;
  logic [15:0]        ret_data;
  logic               ret_ok;
  logic               pop;
  logic               push;
  logic               start_frame;

  // Only the latched source is listened to; the other source's returns are ignored.
  assign ret_dvld = sel_clrb_q ? CLRB_DVLD : SRAM_CTRL_DVLD;
  assign ret_data = sel_clrb_q ? CLRB_DATA : SRAM_CTRL_DATA;
  assign ret_ok   = ret_dvld && (outst_q != '0);
  assign active   = (state_q == S_PREFETCH) || (state_q == S_RUN);

  // A frame start suppresses the request so the flush only waits on earlier ones.
  assign req = active && !VGA_FRAME_START
            && (({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_W)
            && (outst_q < MAXO_C)
            && (issued_q < FRAME_C);

  assign pop  = (state_q == S_RUN) && !VGA_FRAME_START && VGA_REQ && (count_q != '0);
  assign push = ret_ok && active && ((count_q != DEPTH_C) || pop);

  always_comb begin
    state_d     = state_q;
    sel_clrb_d  = sel_clrb_q;
    addr_d      = addr_q;
    issued_d    = issued_q;
    outst_d     = outst_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pix_dvld_d  = VGA_REQ;
    pix_data_d  = pix_data_q;
    underflow_d = underflow_q;
    start_frame = 1'b0;

    if (req) begin
      issued_d = issued_q + 1'b1;
      if (!sel_clrb_q) begin
        addr_d = addr_q + 1'b1;
      end
    end

    case ({req, ret_ok})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    if (VGA_REQ) begin
      if (pop) begin
        pix_data_d = mem[rd_ptr_q];
      end else begin
        pix_data_d = BLANK;
        if ((state_q == S_RUN) && !VGA_FRAME_START) begin
          underflow_d = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (VGA_FRAME_START) begin
          state_d     = S_PREFETCH;
          start_frame = 1'b1;
        end
      end
      S_PREFETCH: begin
        if (VGA_FRAME_START) begin
          state_d = S_FLUSH;
        end else if ((count_q == DEPTH_C) || ((issued_q == FRAME_C) && (outst_q == '0))) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (VGA_FRAME_START) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        count_d  = '0;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        if ((outst_q == '0) && !VGA_FRAME_START) begin
          state_d     = S_PREFETCH;
          start_frame = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The source choice is sampled only here, so a frame never mixes sources.
    if (start_frame) begin
      addr_d     = '0;
      issued_d   = '0;
      sel_clrb_d = (REG_SELECT == 2'b10);
    end
  end

  always_ff @(posedge CLK_40M) begin
    if (SYS_RST) begin
      state_q     <= S_IDLE;
      sel_clrb_q  <= 1'b0;
      addr_q      <= '0;
      issued_q    <= '0;
      outst_q     <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pix_dvld_q  <= 1'b0;
      pix_data_q  <= BLANK;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_clrb_q  <= sel_clrb_d;
      addr_q      <= addr_d;
      issued_q    <= issued_d;
      outst_q     <= outst_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pix_dvld_q  <= pix_dvld_d;
      pix_data_q  <= pix_data_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge CLK_40M) begin
    if (push) begin
      mem[wr_ptr_q] <= ret_data;
    end
  end

  assign SRAM_RD_REQ  = req && !sel_clrb_q;
  assign CLRB_REQ     = req && sel_clrb_q;
  assign SRAM_RD_ADDR = addr_q;
  assign PIX_DVLD     = pix_dvld_q;
  assign PIX_DATA     = pix_data_q;
  assign UNDERFLOW    = underflow_q;

endmodule

// File: tb/tb_pixel_src_sched.sv
// Directed bench for pixel_src_sched with SRAM and color-bar responders of adjustable latency.
// SRAM pixels carry a per-frame tag in the top nibble, so that stale data can be spotted.
`timescale 1ns/1ps
module tb_pixel_src_sched;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [1:0]  reg_select;
  logic        frame_start;
  logic        vga_req;
  logic        pix_dvld;
  logic [15:0] pix_data;
  logic        clrb_req;
  logic        clrb_dvld;
  logic [15:0] clrb_data;
  logic        sram_rd_req;
  logic [18:0] sram_rd_addr;
  logic        sram_dvld;
  logic [15:0] sram_data;
  logic        underflow;

  always #12.5 clk = ~clk;

  pixel_src_sched #(
    .DEPTH(8), .MAX_OUTST(4), .ADDR_W(19), .FRAME_PIXELS(16), .BLANK(16'h0000)
  ) dut (
    .CLK_40M(clk), .SYS_RST(sys_rst), .REG_SELECT(reg_select),
    .VGA_FRAME_START(frame_start), .VGA_REQ(vga_req),
    .PIX_DVLD(pix_dvld), .PIX_DATA(pix_data),
    .CLRB_REQ(clrb_req), .CLRB_DVLD(clrb_dvld), .CLRB_DATA(clrb_data),
    .SRAM_RD_REQ(sram_rd_req), .SRAM_RD_ADDR(sram_rd_addr),
    .SRAM_CTRL_DVLD(sram_dvld), .SRAM_CTRL_DATA(sram_data),
    .UNDERFLOW(underflow)
  );

  typedef struct {
    int          due;
    logic [15:0] d;
    logic        clrb;
  } rsp_t;

  rsp_t        rq[$];
  logic [18:0] addr_log[$];
  int          addr_cyc[$];
  int          cyc = 0;
  int          lat = 2;
  logic [3:0]  tag = 4'h0;
  int          clrb_cnt = 0;
  int          outst_model = 0;
  int          max_out = 0;
  int          total = 0;
  int          bad = 0;

  // Request monitor: samples the cycle that is ending at each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      if (sram_rd_req) begin
        rq.push_back('{cyc + lat, {tag, sram_rd_addr[11:0]}, 1'b0});
        addr_log.push_back(sram_rd_addr);
        addr_cyc.push_back(cyc);
        outst_model++;
      end
      if (clrb_req) begin
        rq.push_back('{cyc + lat, 16'hC000 | 16'(clrb_cnt[11:0]), 1'b1});
        clrb_cnt++;
        outst_model++;
      end
      if (outst_model > max_out) max_out = outst_model;
      cyc++;
    end
  end

  // Responder: presents at most one return per cycle, on the falling edge.
  initial begin
    sram_dvld = 1'b0; sram_data = 16'h0; clrb_dvld = 1'b0; clrb_data = 16'h0;
    forever begin
      rsp_t r;
      @(negedge clk);
      sram_dvld = 1'b0;
      clrb_dvld = 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        outst_model--;
        if (r.clrb) begin
          clrb_dvld = 1'b1; clrb_data = r.d;
        end else begin
          sram_dvld = 1'b1; sram_data = r.d;
        end
      end
    end
  end

  task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tg, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge: one-cycle pull, checked just after the next rising edge.
  task automatic pull_chk(input string tg, input logic [15:0] exp);
    vga_req = 1'b1;
    @(posedge clk); #1;
    chk({tg, "_dvld"}, {31'b0, pix_dvld}, 32'd1);
    chk({tg, "_data"}, {16'b0, pix_data}, {16'b0, exp});
    @(negedge clk);
    vga_req = 1'b0;
  endtask

  task automatic pulse_frame(input logic [3:0] new_tag);
    tag = new_tag;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int mark;
    int w;
    sys_rst = 1'b1; reg_select = 2'b00; frame_start = 1'b0; vga_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pix_dvld", {31'b0, pix_dvld}, 32'd0);
    chk("rst_pix_data", {16'b0, pix_data}, 32'h0);
    chk("rst_underflow", {31'b0, underflow}, 32'd0);
    chk("rst_sram_req", {31'b0, sram_rd_req}, 32'd0);
    chk("rst_clrb_req", {31'b0, clrb_req}, 32'd0);
    chk("rst_sram_addr", {13'b0, sram_rd_addr}, 32'd0);
    sys_rst = 1'b0;
    cycles(4);
    chk("idle_no_req", addr_log.size(), 32'd0);

    // SRAM frame, 2-cycle return latency
    lat = 2;
    pulse_frame(4'h1);
    pull_chk("prefetch_pull", 16'h0000);
    chk("prefetch_no_underflow", {31'b0, underflow}, 32'd0);
    cycles(30);
    chk("prefetch_issued", addr_log.size(), 32'd8);
    for (int i = 0; i < 8; i++) pull_chk("sram_px_a", {4'h1, 12'(i)});
    @(posedge clk); #1;
    chk("hold_dvld", {31'b0, pix_dvld}, 32'd0);
    chk("hold_data", {16'b0, pix_data}, 32'h1007);
    @(negedge clk);
    reg_select = 2'b10;
    cycles(30);
    for (int i = 8; i < 16; i++) pull_chk("sram_px_b", {4'h1, 12'(i)});
    chk("frame_req_count", addr_log.size(), 32'd16);
    for (int i = 0; i < 16; i++) chk("frame_addr", {13'b0, addr_log[i]}, i);
    cycles(30);
    chk("frame_limit", addr_log.size(), 32'd16);
    chk("no_clrb_midframe", clrb_cnt, 32'd0);
    chk("max_outstanding", {31'b0, (max_out <= 4)}, 32'd1);

    // Frame start together with a pull: answered with BLANK, no underflow
    tag = 4'h2;
    frame_start = 1'b1; vga_req = 1'b1;
    @(posedge clk); #1;
    chk("fs_pull_dvld", {31'b0, pix_dvld}, 32'd1);
    chk("fs_pull_data", {16'b0, pix_data}, 32'h0);
    chk("fs_pull_underflow", {31'b0, underflow}, 32'd0);
    @(negedge clk);
    frame_start = 1'b0; vga_req = 1'b0;
    cycles(30);
    chk("clrb_prefetch", clrb_cnt, 32'd8);
    for (int i = 0; i < 8; i++) pull_chk("clrb_px", 16'hC000 | 16'(i));
    chk("clrb_no_sram", addr_log.size(), 32'd16);
    cycles(30);

    // Frame start with 3 SRAM requests outstanding
    reg_select = 2'b00;
    lat = 10;
    mark = addr_log.size();
    pulse_frame(4'h3);
    for (w = 0; w < 100 && addr_log.size() < mark + 3; w++) @(negedge clk);
    pulse_frame(4'h4);
    chk("three_outstanding", addr_log.size(), mark + 3);
    chk("third_addr", {13'b0, addr_log[mark + 2]}, 32'd2);
    for (w = 0; w < 100 && addr_log.size() < mark + 4; w++) @(negedge clk);
    chk("flush_restart_addr", {13'b0, addr_log[mark + 3]}, 32'd0);
    chk("flush_wait_cycles", addr_cyc[mark + 3] - addr_cyc[mark + 2], 32'd12);
    cycles(60);
    for (int i = 0; i < 8; i++) pull_chk("post_flush_px", {4'h4, 12'(i)});
    cycles(40);

    // Underflow while returns are delayed by 20 cycles
    lat = 2;
    pulse_frame(4'h5);
    cycles(30);
    lat = 20;
    vga_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("uf_dvld", {31'b0, pix_dvld}, 32'd1);
      if (i < 8) begin
        chk("uf_data", {16'b0, pix_data}, {16'h0, 4'h5, 12'(i)});
        chk("uf_flag_clear", {31'b0, underflow}, 32'd0);
      end else begin
        chk("uf_blank", {16'b0, pix_data}, 32'h0);
        chk("uf_flag_set", {31'b0, underflow}, 32'd1);
      end
    end
    @(negedge clk);
    vga_req = 1'b0;
    cycles(40);
    chk("uf_sticky", {31'b0, underflow}, 32'd1);
    pull_chk("uf_refill", 16'h5008);
    chk("uf_sticky2", {31'b0, underflow}, 32'd1);

    // Reset in RUN with 2 requests outstanding
    lat = 2;
    pulse_frame(4'h6);
    cycles(30);
    lat = 30;
    pull_chk("pre_rst_px0", 16'h6000);
    pull_chk("pre_rst_px1", 16'h6001);
    cycles(3);
    chk("pre_rst_outstanding", outst_model, 32'd2);
    sys_rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_underflow", {31'b0, underflow}, 32'd0);
    chk("mid_rst_dvld", {31'b0, pix_dvld}, 32'd0);
    chk("mid_rst_data", {16'b0, pix_data}, 32'h0);
    @(negedge clk);
    sys_rst = 1'b0;
    mark = addr_log.size();
    cycles(40);
    chk("post_rst_idle", addr_log.size(), mark);
    pull_chk("post_rst_pull", 16'h0000);
    chk("post_rst_underflow", {31'b0, underflow}, 32'd0);
    lat = 2;
    pulse_frame(4'h7);
    cycles(30);
    chk("post_rst_issued", addr_log.size(), mark + 8);
    chk("post_rst_addr0", {13'b0, addr_log[mark]}, 32'd0);
    for (int i = 0; i < 8; i++) pull_chk("post_rst_px", {4'h7, 12'(i)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_src_sched.md
Name: pixel_src_sched

Overview:
Frame-synchronous scheduler for the VGA pixel path. It chooses between the color-bar generator and the SRAM read controller as the pixel source, and issues paced read requests to the chosen source. Returned pixels go into a small prefetch FIFO, which serves VGA_REQ pulls at one pixel per request. Source changes take effect only at frame boundaries, so a frame never contains pixels from both sources.

Parameters:
DEPTH, 8, prefetch FIFO depth in pixels (power of 2, 4..32)
MAX_OUTST, 4, maximum source requests issued but not yet returned (1..DEPTH)
ADDR_W, 19, SRAM pixel address width
FRAME_PIXELS, 480000, pixels per frame (800x600)
BLANK, 16'h0000, pixel value output on underflow or when not running

Ports:
CLK_40M  in  1  clock 40MHz
SYS_RST  in  1  system reset, synchronous, active-high
REG_SELECT  in  2  source select; 2'b10 = color bar, any other value = SRAM
VGA_FRAME_START  in  1  one-cycle pulse at start of vertical blanking
VGA_REQ  in  1  pixel pull, one pixel per high cycle
PIX_DVLD  out  1  pixel valid, answers VGA_REQ
PIX_DATA  out  16  pixel data
CLRB_REQ  out  1  one-cycle request to color-bar generator
CLRB_DVLD  in  1  color-bar data valid
CLRB_DATA  in  16  color-bar pixel
SRAM_RD_REQ  out  1  one-cycle read request to SRAM controller
SRAM_RD_ADDR  out  ADDR_W  pixel address, valid while SRAM_RD_REQ is high
SRAM_CTRL_DVLD  in  1  SRAM read data valid
SRAM_CTRL_DATA  in  16  SRAM read data
UNDERFLOW  out  1  sticky flag: VGA_REQ arrived while the FIFO was empty in RUN

Behaviour:
- Clock and reset: one clock, CLK_40M. SYS_RST is synchronous and active-high.
- Reset values: state=IDLE; FIFO empty; outstanding=0; addr=0; sel_lat=SRAM; all outputs 0; PIX_DATA=BLANK.
- sel_lat is loaded from REG_SELECT only on the transition into PREFETCH. It drives request routing and return-data selection. The return of the non-selected source is ignored.
- States:
  - IDLE: no requests issued. On VGA_FRAME_START go to PREFETCH.
  - PREFETCH: issue requests. Go to RUN when the FIFO is full, or when issued == FRAME_PIXELS and outstanding == 0.
  - RUN: issue requests and serve pulls.
  - FLUSH: entered on VGA_FRAME_START from PREFETCH or RUN. Issue no requests, clear the FIFO, and discard returning data. Once outstanding == 0: addr=0, issued=0, latch sel_lat, go to PREFETCH. A VGA_FRAME_START arriving during FLUSH is absorbed; stay in FLUSH.
- Request rule: at most one request per cycle, issued when fifo_count + outstanding < DEPTH, outstanding < MAX_OUTST, and issued < FRAME_PIXELS.
  - SRAM_RD_ADDR = addr; addr increments after each SRAM request.
  - Color-bar requests also count toward issued but do not drive addr.
- Outstanding counter: +1 on request, -1 on selected-source DVLD, unchanged when both occur in the same cycle. A DVLD received with outstanding == 0 is dropped and does not underflow the counter.
- FIFO write: on selected-source DVLD while in PREFETCH or RUN. Headroom is guaranteed by the request rule; a write while full is an error and is dropped.
- Serve (RUN only), 1-cycle latency: VGA_REQ high in cycle N gives PIX_DVLD=1 in N+1.
  - FIFO non-empty: PIX_DATA = FIFO head, popped in cycle N.
  - FIFO empty: PIX_DATA=BLANK and UNDERFLOW is set.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
- VGA_REQ outside RUN: PIX_DVLD=1 next cycle with PIX_DATA=BLANK; UNDERFLOW is not set.
- PIX_DATA holds its last value while PIX_DVLD=0.
- VGA_FRAME_START in the same cycle as VGA_REQ: the frame start wins. The request is answered with BLANK and the block enters FLUSH.
- UNDERFLOW clears only on SYS_RST.
- Reset mid-operation: immediate return to reset values. Data returned after reset for pre-reset requests is dropped by the outstanding==0 rule.

Test Plan:
- Reset, then a frame start with REG_SELECT=2'b00; SRAM returns data 2 cycles after each request -> SRAM_RD_ADDR issues 0,1,2,...; at most 4 requests outstanding; RUN after 8 pixels are buffered; 8 VGA_REQ cycles yield PIX_DATA equal to SRAM data for addr 0..7, in order, each 1 cycle later.
- Change REG_SELECT to 2'b10 mid-frame -> SRAM continues until the next VGA_FRAME_START; after FLUSH, CLRB_REQ pulses and the first served pixel equals CLRB_DATA.
- VGA_FRAME_START with 3 requests outstanding -> the block stays in FLUSH until 3 DVLDs are discarded; next frame's first SRAM_RD_ADDR=0; no stale pixel is output.
- SRAM delays DVLD by 20 cycles while VGA_REQ is held high -> PIX_DATA=BLANK with PIX_DVLD=1; UNDERFLOW=1 and remains set until SYS_RST.
- FRAME_PIXELS=16 -> exactly 16 requests per frame with SRAM_RD_ADDR 0..15; no further requests until the next frame start.
- SYS_RST asserted in RUN with 2 outstanding, late DVLDs arriving after reset -> FIFO stays empty, outstanding=0, state=IDLE.
